// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction fetch stage: drives the ROM address, registers the fetched
// word with its PC, and applies branches, stalls and HALT detection.
module pc_fetch_ctrl #(
    parameter int unsigned             PC_W        = 10,
    parameter int unsigned             INSTR_W     = 9,
    parameter logic [INSTR_W-1:0]      HALT_OPCODE = 9'h1FF,
    parameter logic [PC_W-1:0]         START_ADDR  = '0,
    parameter int unsigned             CNT_W       = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [PC_W-1:0]    branch_target_i,
    output logic [PC_W-1:0]    rom_addr_o,
    input  logic [INSTR_W-1:0] rom_data_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    instr_pc_o,
    output logic               instr_valid_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   cycle_count_o
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    ipc_q, ipc_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            StRun: begin
                // Counts every RUN cycle, stalls and bubbles included
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                if (valid_q && (instr_q == HALT_OPCODE)) begin
                    state_d = StHalt;
                    done_d  = 1'b1;
                    valid_d = 1'b0;
                end else if (stall_i) begin
                    // Hold everything; a pending branch is re-presented after the stall
                end else if (valid_q && branch_taken_i) begin
                    pc_d    = branch_target_i;
                    valid_d = 1'b0;
                end else begin
                    instr_d = rom_data_i;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_W'(1);
                end
            end
            StHalt: begin
                if (start_i) begin
                    state_d = StRun;
                    pc_d    = START_ADDR;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            pc_q    <= START_ADDR;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rom_addr_o    = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = ipc_q;
    assign instr_valid_o = valid_q;
    assign done_o        = done_q;
    assign cycle_count_o = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Table-driven bench for pc_fetch_ctrl: a per-cycle vector table for the program flow,
// plus hand sequences for async reset and cycle-counter saturation.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic        bt;
    logic [9:0]  tgt;
    logic [9:0]  rom_addr;
    logic [8:0]  rom_data;
    logic [8:0]  instr;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        done;
    logic [15:0] cycle_count;

    logic [8:0]  rom [1024];
    assign rom_data = rom[rom_addr];

    pc_fetch_ctrl dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (start),
        .stall_i        (stall),
        .branch_taken_i (bt),
        .branch_target_i(tgt),
        .rom_addr_o     (rom_addr),
        .rom_data_i     (rom_data),
        .instr_o        (instr),
        .instr_pc_o     (instr_pc),
        .instr_valid_o  (instr_valid),
        .done_o         (done),
        .cycle_count_o  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        stall;
        logic        bt;
        logic [9:0]  tgt;
        logic        valid;
        logic [9:0]  ipc;
        logic [8:0]  instr;
        logic        done;
        logic [15:0] cnt;
        logic [9:0]  addr;
    } vec_t;

    vec_t vt [24];
    int   n_vec;
    int   n_miss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input int i);
        start = vt[i].start;
        stall = vt[i].stall;
        bt    = vt[i].bt;
        tgt   = vt[i].tgt;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d.valid", i), 32'(instr_valid), 32'(vt[i].valid));
        chk($sformatf("v%0d.instr_pc", i), 32'(instr_pc), 32'(vt[i].ipc));
        chk($sformatf("v%0d.instr", i), 32'(instr), 32'(vt[i].instr));
        chk($sformatf("v%0d.done", i), 32'(done), 32'(vt[i].done));
        chk($sformatf("v%0d.cycle_count", i), 32'(cycle_count), 32'(vt[i].cnt));
        chk($sformatf("v%0d.rom_addr", i), 32'(rom_addr), 32'(vt[i].addr));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        for (int a = 0; a < 1024; a++) rom[a] = {1'b0, a[7:0]};
        rom[0] = 9'h010;
        rom[1] = 9'h011;
        rom[2] = 9'h012;
        rom[3] = 9'h1FF;

        //        start stall bt  tgt      valid ipc     instr    done cnt    addr
        vt[0]  = '{1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 9'h000, 1'b0, 16'd0,  10'h000};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h000, 9'h010, 1'b0, 16'd1,  10'h001};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h001, 9'h011, 1'b0, 16'd2,  10'h002};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h002, 9'h012, 1'b0, 16'd3,  10'h003};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h003, 9'h1FF, 1'b0, 16'd4,  10'h004};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h003, 9'h1FF, 1'b1, 16'd5,  10'h004};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h003, 9'h1FF, 1'b1, 16'd5,  10'h004};
        vt[7]  = '{1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 10'h003, 9'h1FF, 1'b0, 16'd0,  10'h000};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 10'h000, 9'h010, 1'b0, 16'd1,  10'h001};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h001, 9'h011, 1'b0, 16'd2,  10'h002};
        vt[10] = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h002, 9'h012, 1'b0, 16'd3,  10'h003};
        vt[11] = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h003, 9'h013, 1'b0, 16'd4,  10'h004};
        vt[12] = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h004, 9'h004, 1'b0, 16'd5,  10'h005};
        vt[13] = '{1'b0, 1'b1, 1'b1, 10'h020, 1'b1, 10'h004, 9'h004, 1'b0, 16'd6,  10'h005};
        vt[14] = '{1'b0, 1'b1, 1'b1, 10'h020, 1'b1, 10'h004, 9'h004, 1'b0, 16'd7,  10'h005};
        vt[15] = '{1'b0, 1'b1, 1'b1, 10'h020, 1'b1, 10'h004, 9'h004, 1'b0, 16'd8,  10'h005};
        vt[16] = '{1'b0, 1'b0, 1'b1, 10'h020, 1'b0, 10'h004, 9'h004, 1'b0, 16'd9,  10'h020};
        vt[17] = '{1'b0, 1'b0, 1'b1, 10'h030, 1'b1, 10'h020, 9'h020, 1'b0, 16'd10, 10'h021};
        vt[18] = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h021, 9'h021, 1'b0, 16'd11, 10'h022};
        vt[19] = '{1'b0, 1'b0, 1'b1, 10'h3FE, 1'b0, 10'h021, 9'h021, 1'b0, 16'd12, 10'h3FE};
        vt[20] = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h3FE, 9'h0FE, 1'b0, 16'd13, 10'h3FF};
        vt[21] = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h3FF, 9'h0FF, 1'b0, 16'd14, 10'h000};
        vt[22] = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h000, 9'h010, 1'b0, 16'd15, 10'h001};
        vt[23] = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h001, 9'h011, 1'b0, 16'd16, 10'h002};

        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        bt    = 1'b0;
        tgt   = '0;
        #1;
        chk("reset.valid", 32'(instr_valid), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.cycle_count", 32'(cycle_count), 32'd0);
        chk("reset.instr", 32'(instr), 32'd0);
        chk("reset.rom_addr", 32'(rom_addr), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        // IDLE must not advance without start
        repeat (2) @(posedge clk);
        #1;
        chk("idle.valid", 32'(instr_valid), 32'd0);
        chk("idle.cycle_count", 32'(cycle_count), 32'd0);

        for (int i = 0; i < 7; i++) apply_vec(i);
        rom[3] = 9'h013;
        for (int i = 7; i < 24; i++) apply_vec(i);

        // Async reset between edges while running
        start = 1'b0;
        stall = 1'b0;
        bt    = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("areset.valid", 32'(instr_valid), 32'd0);
        chk("areset.instr", 32'(instr), 32'd0);
        chk("areset.instr_pc", 32'(instr_pc), 32'd0);
        chk("areset.cycle_count", 32'(cycle_count), 32'd0);
        chk("areset.rom_addr", 32'(rom_addr), 32'd0);
        chk("areset.done", 32'(done), 32'd0);
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_idle.valid", 32'(instr_valid), 32'd0);
        chk("post_reset_idle.cycle_count", 32'(cycle_count), 32'd0);
        chk("post_reset_idle.rom_addr", 32'(rom_addr), 32'd0);

        // Cycle counter saturation while stalled in RUN
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stall = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat.cycle_count", 32'(cycle_count), 32'h0000FFFF);
        chk("sat.valid", 32'(instr_valid), 32'd0);
        chk("sat.done", 32'(done), 32'd0);
        chk("sat.rom_addr", 32'(rom_addr), 32'd0);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_hold.cycle_count", 32'(cycle_count), 32'h0000FFFF);
        chk("sat_hold.valid", 32'(instr_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
